// File: rtl/ama_riscv_flow_ctrl.sv
// Pipeline flow control: PC mux select, pipeline clears, branch prediction
// policy (stall / static not-taken / BTFN), reset clear sequence and perf counters.
module ama_riscv_flow_ctrl #(
   parameter int BP_MODE     = 1,
   parameter int RST_SEQ_LEN = 3,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_id,
   input  logic [31:0]      inst_ex,
   input  logic             bc_a_eq_b,
   input  logic             bc_a_lt_b,
   output logic [2:0]       pc_sel,
   output logic             pc_we,
   output logic             clear_if,
   output logic             clear_id,
   output logic             bc_uns,
   output logic             mispredict,
   output logic             rst_seq_busy,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mp_cnt
);

   localparam logic [1:0] RSEQ = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   localparam logic [1:0] CF_NONE   = 2'd0;
   localparam logic [1:0] CF_BRANCH = 2'd1;
   localparam logic [1:0] CF_JAL    = 2'd2;
   localparam logic [1:0] CF_JALR   = 2'd3;

   localparam logic [2:0] PC_INC4    = 3'd0;
   localparam logic [2:0] PC_ALU     = 3'd1;
   localparam logic [2:0] PC_BP      = 3'd2;
   localparam logic [2:0] PC_EX_INC4 = 3'd3;
   localparam logic [2:0] PC_START   = 3'd4;

   localparam logic [2:0] SEQ_LEN = 3'(RST_SEQ_LEN);

   logic [1:0] state, state_nx;
   logic [2:0] seq_cnt;
   logic [1:0] cls_id, cls_ex;
   logic       pred_id, pred_ex;
   logic       taken_ex;
   logic       redirect;
   logic       unused_bits;

   assign unused_bits = ^{inst_id[30:14], inst_id[12:7], inst_ex[31:15], inst_ex[13], inst_ex[11:0]};

   always_comb begin
      cls_id = CF_NONE;
      case (inst_id[6:0])
         7'b1100011: cls_id = CF_BRANCH;
         7'b1101111: cls_id = CF_JAL;
         7'b1100111: cls_id = CF_JALR;
         default:    cls_id = CF_NONE;
      endcase
   end

   assign pred_id = (BP_MODE == 2) &&
                    ((cls_id == CF_JAL) || ((cls_id == CF_BRANCH) && inst_id[31]));
   assign bc_uns  = (cls_id == CF_BRANCH) && inst_id[13];

   // Branch condition selected by {funct3[2], funct3[0]}: bit 2 picks lt vs eq, bit 0 inverts
   always_comb begin
      taken_ex = 1'b0;
      case (cls_ex)
         CF_BRANCH: taken_ex = (inst_ex[14] ? bc_a_lt_b : bc_a_eq_b) ^ inst_ex[12];
         CF_JAL, CF_JALR: taken_ex = 1'b1;
         default: taken_ex = 1'b0;
      endcase
   end

   always_comb begin
      redirect = 1'b0;
      if (cls_ex != CF_NONE) begin
         if (BP_MODE == 1)      redirect = taken_ex;
         else if (BP_MODE == 2) redirect = (taken_ex != pred_ex);
      end
   end

   always_comb begin
      pc_sel       = PC_INC4;
      pc_we        = 1'b1;
      clear_if     = 1'b0;
      clear_id     = 1'b0;
      mispredict   = 1'b0;
      rst_seq_busy = 1'b0;
      state_nx     = state;
      if (rst) begin
         pc_sel       = PC_START;
         clear_if     = 1'b1;
         clear_id     = 1'b1;
         rst_seq_busy = 1'b1;
         state_nx     = RSEQ;
      end else begin
         case (state)
            RSEQ: begin
               pc_sel       = (seq_cnt == SEQ_LEN) ? PC_START : PC_INC4;
               clear_if     = 1'b1;
               clear_id     = 1'b1;
               rst_seq_busy = 1'b1;
               if (seq_cnt <= 3'd1) state_nx = RUN;
            end
            WAIT: begin
               pc_sel   = taken_ex ? PC_ALU : PC_INC4;
               state_nx = RUN;
            end
            default: begin
               if (redirect) begin
                  pc_sel     = taken_ex ? PC_ALU : PC_EX_INC4;
                  clear_if   = 1'b1;
                  clear_id   = 1'b1;
                  mispredict = 1'b1;
               end else if ((BP_MODE == 0) && (cls_id != CF_NONE)) begin
                  pc_we    = 1'b0;
                  clear_if = 1'b1;
                  state_nx = WAIT;
               end else if (pred_id) begin
                  pc_sel   = PC_BP;
                  clear_if = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RSEQ;
         seq_cnt <= SEQ_LEN;
         cls_ex  <= CF_NONE;
         pred_ex <= 1'b0;
         br_cnt  <= '0;
         mp_cnt  <= '0;
      end else begin
         state <= state_nx;
         if ((state == RSEQ) && (seq_cnt != 3'd0)) seq_cnt <= seq_cnt - 3'd1;
         // A flushed ID slot enters EX as a bubble, so it is never resolved or counted
         cls_ex  <= clear_id ? CF_NONE : cls_id;
         pred_ex <= clear_id ? 1'b0 : pred_id;
         if ((cls_ex != CF_NONE) && !(&br_cnt)) br_cnt <= br_cnt + 1'b1;
         if (mispredict && !(&mp_cnt)) mp_cnt <= mp_cnt + 1'b1;
      end
   end

endmodule
